// File: rtl/la_checkpoint_monitor_if.sv
// ---------------------------------------------------------------------------
// la_checkpoint_monitor_if
// Groups the checkpoint bus, the table/run configuration and the run status
// of la_checkpoint_monitor into one bundle.
//   master : drives check/config/arm/abort, observes status (LA side, bench)
//   slave  : the monitor itself
// Signals:
//   check_i    WIDTH    monitored checkpoint bus
//   cfg_we_i   1        table write strobe
//   cfg_idx_i  IW       table entry index
//   cfg_data_i WIDTH    expected value for entry cfg_idx_i
//   cfg_len_i  IW+1     number of active entries (latched at arm)
//   timeout_i  TMO_W    per-stage cycle limit, 0 = disabled (latched at arm)
//   arm_i      1        start monitoring
//   abort_i    1        abandon an armed run
//   busy_o     1        run armed and in progress
//   pass_o     1        all active entries seen in order
//   fail_o     1        run failed
//   err_o      2        00 none, 01 timeout, 10 order, 11 abort
//   stage_o    IW+1     entries completed so far
// ---------------------------------------------------------------------------
interface la_checkpoint_monitor_if #(
    parameter int WIDTH      = 16,
    parameter int NUM_CHECKS = 4,
    parameter int TMO_W      = 24
);
    localparam int IW = $clog2(NUM_CHECKS);

    logic [WIDTH-1:0] check_i;
    logic             cfg_we_i;
    logic [IW-1:0]    cfg_idx_i;
    logic [WIDTH-1:0] cfg_data_i;
    logic [IW:0]      cfg_len_i;
    logic [TMO_W-1:0] timeout_i;
    logic             arm_i;
    logic             abort_i;
    logic             busy_o;
    logic             pass_o;
    logic             fail_o;
    logic [1:0]       err_o;
    logic [IW:0]      stage_o;

    modport master (
        output check_i, cfg_we_i, cfg_idx_i, cfg_data_i, cfg_len_i,
               timeout_i, arm_i, abort_i,
        input  busy_o, pass_o, fail_o, err_o, stage_o
    );

    modport slave (
        input  check_i, cfg_we_i, cfg_idx_i, cfg_data_i, cfg_len_i,
               timeout_i, arm_i, abort_i,
        output busy_o, pass_o, fail_o, err_o, stage_o
    );
endinterface

// File: rtl/la_checkpoint_monitor.sv
// ---------------------------------------------------------------------------
// la_checkpoint_monitor
// Watches a checkpoint bus for an ordered sequence of programmed signature
// values and reports progress, pass/fail and the failure cause. Each value
// must be sampled HOLD consecutive cycles before it counts as an event, each
// stage can be bounded by a cycle timeout, and an event matching a later
// table entry before the expected one is flagged as an order error.
// Ports:
//   wb_clk_i  sole clock, rising edge
//   wb_rst_i  synchronous active-high reset
//   bus       la_checkpoint_monitor_if.slave (check bus, config, status)
//
// State table
//   state   | meaning
//   IDLE    | not armed since reset; table writable
//   ARMED   | run in progress; table writes ignored
//   PASS    | all active entries seen in order (sticky until arm/reset)
//   FAIL    | timeout, order error or abort (sticky until arm/reset)
// ---------------------------------------------------------------------------
module la_checkpoint_monitor #(
    parameter int WIDTH      = 16,
    parameter int NUM_CHECKS = 4,
    parameter int HOLD       = 1,
    parameter int TMO_W      = 24
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    la_checkpoint_monitor_if.slave bus
);
    localparam int          IW      = $clog2(NUM_CHECKS);
    localparam int          RW      = $clog2(HOLD + 2);
    localparam logic [IW:0] LEN_MAX = (IW+1)'(NUM_CHECKS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_PASS  = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_TMO   = 2'b01;
    localparam logic [1:0] ERR_ORDER = 2'b10;
    localparam logic [1:0] ERR_ABORT = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tbl_q [NUM_CHECKS];
    logic [IW:0]      stage_q, stage_d;
    logic [IW:0]      len_q, len_d;
    logic [IW:0]      len_arm;
    logic [IW:0]      stage_inc;
    logic [1:0]       err_q, err_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [TMO_W-1:0] lim_q, lim_d;
    logic [WIDTH-1:0] prev_q;
    logic [RW-1:0]    run_q, run_d;
    logic             busy_q, busy_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             evt;
    logic             match_cur;
    logic             match_ahead;
    logic             tmo_hit;
    logic             arm_take;
    logic             tbl_we;

    // Stability filter. run saturates at HOLD+1 so the event (run == HOLD)
    // fires exactly once per stable run, however long the value is held.
    always_comb begin
        run_d = RW'(1);
        if (bus.check_i == prev_q) begin
            run_d = (run_q == RW'(HOLD + 1)) ? run_q : run_q + RW'(1);
        end
        evt = (run_d == RW'(HOLD));
    end

    always_comb begin
        match_ahead = 1'b0;
        for (int j = 0; j < NUM_CHECKS; j++) begin
            if (((IW+1)'(j) > stage_q) && ((IW+1)'(j) < len_q) &&
                (bus.check_i == tbl_q[j])) begin
                match_ahead = 1'b1;
            end
        end
        match_ahead = match_ahead & evt;
    end

    always_comb begin
        len_arm = bus.cfg_len_i;
        if (bus.cfg_len_i == '0) begin
            len_arm = (IW+1)'(1);
        end else if (bus.cfg_len_i > LEN_MAX) begin
            len_arm = LEN_MAX;
        end
    end

    // stage_q < len_q <= NUM_CHECKS whenever ARMED, so the low bits index
    // the table safely.
    assign match_cur = evt && (bus.check_i == tbl_q[stage_q[IW-1:0]]);
    assign tmo_hit   = (lim_q != '0) && (tmo_q == lim_q - TMO_W'(1));
    assign stage_inc = stage_q + (IW+1)'(1);
    assign arm_take  = bus.arm_i && (state_q != S_ARMED);
    assign tbl_we    = bus.cfg_we_i && (state_q != S_ARMED) &&
                       (int'(bus.cfg_idx_i) < NUM_CHECKS);

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and run bookkeeping
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        len_d   = len_q;
        lim_d   = lim_q;
        case (state_q)
            S_ARMED: begin
                if (bus.abort_i) begin
                    state_d = S_FAIL;
                    err_d   = ERR_ABORT;
                end else if (match_cur) begin
                    stage_d = stage_inc;
                    tmo_d   = '0;
                    if (stage_inc == len_q) begin
                        state_d = S_PASS;
                    end
                end else if (match_ahead) begin
                    state_d = S_FAIL;
                    err_d   = ERR_ORDER;
                end else if (tmo_hit) begin
                    state_d = S_FAIL;
                    err_d   = ERR_TMO;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                if (bus.arm_i) begin
                    state_d = S_ARMED;
                    len_d   = len_arm;
                    lim_d   = bus.timeout_i;
                    stage_d = '0;
                    err_d   = ERR_NONE;
                    tmo_d   = '0;
                end
            end
        endcase
    end

    // Status flags, registered from the next state
    always_comb begin
        busy_d = (state_d == S_ARMED);
        pass_d = (state_d == S_PASS);
        fail_d = (state_d == S_FAIL);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                tbl_q[i] <= '0;
            end
            stage_q <= '0;
            len_q   <= (IW+1)'(1);
            err_q   <= ERR_NONE;
            tmo_q   <= '0;
            lim_q   <= '0;
            prev_q  <= '0;
            run_q   <= '0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            if (tbl_we) begin
                tbl_q[bus.cfg_idx_i] <= bus.cfg_data_i;
            end
            stage_q <= stage_d;
            len_q   <= len_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            lim_q   <= lim_d;
            prev_q  <= bus.check_i;
            // A value already on the bus at arm must be re-held HOLD cycles.
            run_q   <= arm_take ? '0 : run_d;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.pass_o  = pass_q;
    assign bus.fail_o  = fail_q;
    assign bus.err_o   = err_q;
    assign bus.stage_o = stage_q;

endmodule

// File: tb/tb_la_checkpoint_monitor.sv
// ---------------------------------------------------------------------------
// tb_la_checkpoint_monitor
// Two monitors share one stimulus stream: u_dut1 with HOLD=1 and u_dut3 with
// HOLD=3. Each directed step drives the bus, queues the status expected after
// the next edge and compares it against the selected monitor.
// Status word layout: {busy, pass, fail, err[1:0], stage[2:0]}.
// ---------------------------------------------------------------------------
module tb_la_checkpoint_monitor;
    localparam int WIDTH = 16;
    localparam int NC    = 4;
    localparam int TMO_W = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    la_checkpoint_monitor_if #(.WIDTH(WIDTH), .NUM_CHECKS(NC), .TMO_W(TMO_W)) bus1 ();
    la_checkpoint_monitor_if #(.WIDTH(WIDTH), .NUM_CHECKS(NC), .TMO_W(TMO_W)) bus3 ();

    assign bus3.check_i    = bus1.check_i;
    assign bus3.cfg_we_i   = bus1.cfg_we_i;
    assign bus3.cfg_idx_i  = bus1.cfg_idx_i;
    assign bus3.cfg_data_i = bus1.cfg_data_i;
    assign bus3.cfg_len_i  = bus1.cfg_len_i;
    assign bus3.timeout_i  = bus1.timeout_i;
    assign bus3.arm_i      = bus1.arm_i;
    assign bus3.abort_i    = bus1.abort_i;

    la_checkpoint_monitor #(.WIDTH(WIDTH), .NUM_CHECKS(NC), .HOLD(1), .TMO_W(TMO_W)) u_dut1 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus1.slave)
    );

    la_checkpoint_monitor #(.WIDTH(WIDTH), .NUM_CHECKS(NC), .HOLD(3), .TMO_W(TMO_W)) u_dut3 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus3.slave)
    );

    wire [7:0] obs1 = {bus1.busy_o, bus1.pass_o, bus1.fail_o, bus1.err_o, bus1.stage_o};
    wire [7:0] obs3 = {bus3.busy_o, bus3.pass_o, bus3.fail_o, bus3.err_o, bus3.stage_o};

    int         n_assert = 0;
    int         n_fail   = 0;
    logic       sel3     = 1'b0;
    logic [7:0] exp_q[$];
    string      tag_q[$];

    function automatic logic [7:0] st(input logic b, input logic p, input logic f,
                                      input logic [1:0] e, input logic [2:0] s);
        return {b, p, f, e, s};
    endfunction

    task automatic step(input logic [WIDTH-1:0] chk, input logic [7:0] exp_v, input string tag);
        logic [7:0] e;
        logic [7:0] o;
        string      t;
        bus1.check_i = chk;
        exp_q.push_back(exp_v);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = sel3 ? obs3 : obs1;
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", t, o, e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic arm_run(input logic [2:0] len, input logic [TMO_W-1:0] tmo,
                           input logic [WIDTH-1:0] chk, input logic [7:0] exp_v,
                           input string tag);
        bus1.cfg_len_i = len;
        bus1.timeout_i = tmo;
        bus1.arm_i     = 1'b1;
        step(chk, exp_v, tag);
        bus1.arm_i     = 1'b0;
    endtask

    task automatic wr(input logic [1:0] idx, input logic [WIDTH-1:0] data,
                      input logic [WIDTH-1:0] chk, input logic [7:0] exp_v,
                      input string tag);
        bus1.cfg_we_i   = 1'b1;
        bus1.cfg_idx_i  = idx;
        bus1.cfg_data_i = data;
        step(chk, exp_v, tag);
        bus1.cfg_we_i   = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus1.check_i    = '0;
        bus1.cfg_we_i   = 1'b0;
        bus1.cfg_idx_i  = '0;
        bus1.cfg_data_i = '0;
        bus1.cfg_len_i  = 3'd1;
        bus1.timeout_i  = '0;
        bus1.arm_i      = 1'b0;
        bus1.abort_i    = 1'b0;

        // Reset
        step(16'h0000, st(0,0,0,2'b00,3'd0), "reset");
        step(16'h0000, st(0,0,0,2'b00,3'd0), "reset_hold");
        rst = 1'b0;

        // Table {AB40, AB41}
        wr(2'd0, 16'hAB40, 16'h0000, st(0,0,0,2'b00,3'd0), "wr0_idle");
        wr(2'd1, 16'hAB41, 16'h0000, st(0,0,0,2'b00,3'd0), "wr1_idle");

        // Pass sequence, HOLD=1
        sel3 = 1'b0;
        arm_run(3'd2, '0, 16'h0000, st(1,0,0,2'b00,3'd0), "pass_arm");
        step(16'hAB40, st(1,0,0,2'b00,3'd1), "pass_stage1");
        step(16'hAB41, st(0,1,0,2'b00,3'd2), "pass_done");
        step(16'hAB41, st(0,1,0,2'b00,3'd2), "pass_sticky");

        // Abort outside ARMED is ignored (dut1 in PASS; dut3 still armed)
        bus1.abort_i = 1'b1;
        step(16'hAB41, st(0,1,0,2'b00,3'd2), "abort_ignored");
        bus1.abort_i = 1'b0;

        // Glitch filter, HOLD=3
        sel3 = 1'b1;
        arm_run(3'd2, '0, 16'hAB41, st(1,0,0,2'b00,3'd0), "glitch_arm");
        step(16'hAB40, st(1,0,0,2'b00,3'd0), "glitch_r1a");
        step(16'hAB40, st(1,0,0,2'b00,3'd0), "glitch_r1b");
        step(16'h0000, st(1,0,0,2'b00,3'd0), "glitch_gap");
        step(16'hAB40, st(1,0,0,2'b00,3'd0), "glitch_r2a");
        step(16'hAB40, st(1,0,0,2'b00,3'd0), "glitch_r2b");
        step(16'hAB40, st(1,0,0,2'b00,3'd1), "glitch_advance");
        for (int i = 0; i < 10; i++) begin
            step(16'hAB40, st(1,0,0,2'b00,3'd1), "glitch_long_hold");
        end

        // Abort while ARMED
        bus1.abort_i = 1'b1;
        step(16'hAB40, st(0,0,1,2'b11,3'd1), "abort_err");
        bus1.abort_i = 1'b0;

        // Re-arm with AB40 already present; write while ARMED must be dropped
        arm_run(3'd2, '0, 16'hAB40, st(1,0,0,2'b00,3'd0), "rearm");
        wr(2'd1, 16'h1234, 16'hAB40, st(1,0,0,2'b00,3'd0), "rearm_h1_wr");
        step(16'hAB40, st(1,0,0,2'b00,3'd0), "rearm_h2");
        step(16'hAB40, st(1,0,0,2'b00,3'd1), "rearm_h3_adv");
        step(16'hAB41, st(1,0,0,2'b00,3'd1), "tbl_keep_h1");
        step(16'hAB41, st(1,0,0,2'b00,3'd1), "tbl_keep_h2");
        step(16'hAB41, st(0,1,0,2'b00,3'd2), "tbl_keep_pass");

        // Order error, HOLD=1, table {AB40, AB41, AB42}
        sel3 = 1'b0;
        wr(2'd2, 16'hAB42, 16'hAB41, st(0,1,0,2'b00,3'd2), "wr2_pass");
        arm_run(3'd3, '0, 16'hAB41, st(1,0,0,2'b00,3'd0), "order_arm");
        step(16'hAB40, st(1,0,0,2'b00,3'd1), "order_stage1");
        step(16'hAB42, st(0,0,1,2'b10,3'd1), "order_err");

        // Timeout 100 with no activity
        arm_run(3'd2, 24'd100, 16'h0000, st(1,0,0,2'b00,3'd0), "tmo_arm");
        idle(98);
        step(16'h0000, st(1,0,0,2'b00,3'd0), "tmo_edge99");
        step(16'h0000, st(0,0,1,2'b01,3'd0), "tmo_fail");

        // Advance on the timeout edge wins
        arm_run(3'd2, 24'd100, 16'h0000, st(1,0,0,2'b00,3'd0), "race_arm");
        idle(99);
        step(16'hAB40, st(1,0,0,2'b00,3'd1), "race_advance");
        step(16'hAB40, st(1,0,0,2'b00,3'd1), "race_no_fail");

        // Reset mid-run, then table must read back as cleared (len 0 -> 1)
        rst = 1'b1;
        step(16'hAB40, st(0,0,0,2'b00,3'd0), "rst_midrun");
        rst = 1'b0;
        arm_run(3'd0, '0, 16'h0000, st(1,0,0,2'b00,3'd0), "clr_arm");
        step(16'h0000, st(0,1,0,2'b00,3'd1), "clr_len1_pass");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/la_checkpoint_monitor.md
# la_checkpoint_monitor

On-chip, synthesizable checkpoint monitor for the user project. It watches a WIDTH-bit checkpoint bus, typically the firmware-driven mprj_io[31:16] or LA outputs, for an ordered sequence of up to NUM_CHECKS programmed signature values (e.g. 16'hAB40 start, 16'hAB41 pass). It reports progress and pass/fail status with a per-stage timeout, a hold-time glitch filter and out-of-order detection. This lets a firmware checkpoint test be judged in silicon, through LA inputs, rather than only by a simulation testbench.

## Interface
- WIDTH, 16: checkpoint bus width.
- NUM_CHECKS, 4: checkpoint table depth (≥2); IW = $clog2(NUM_CHECKS).
- HOLD, 1: consecutive cycles a value must be sampled to count as an event (≥1).
- TMO_W, 24: timeout counter width.

- wb_clk_i  in  1  sole clock, all logic on rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- check_i  in  WIDTH  monitored checkpoint bus, synchronous to wb_clk_i.
- cfg_we_i  in  1  table write strobe.
- cfg_idx_i  in  IW  table entry index.
- cfg_data_i  in  WIDTH  expected value for entry cfg_idx_i.
- cfg_len_i  in  IW+1  number of active entries, 1..NUM_CHECKS; latched at arm.
- timeout_i  in  TMO_W  per-stage cycle limit; 0 = disabled; latched at arm.
- arm_i  in  1  start monitoring (pulse).
- abort_i  in  1  abandon an armed run.
- busy_o  out  1  run armed and in progress.
- pass_o  out  1  all active entries seen in order.
- fail_o  out  1  run failed.
- err_o  out  2  00 none, 01 timeout, 10 order, 11 abort.
- stage_o  out  IW+1  index of next expected entry / entries completed.

## Operation
- States: IDLE, ARMED, PASS, FAIL. Reset: IDLE, all outputs 0, table entries 0, len_q = 1, tmo_lim_q = 0, prev_q = 0, run_q = 0.
- Table writes are accepted when cfg_we_i is high and the state is not ARMED. They are ignored while ARMED. cfg_idx_i ≥ NUM_CHECKS is ignored.
- Arm: arm_i in IDLE, PASS or FAIL → ARMED. The arm edge does the following:
  - latches cfg_len_i into len_q, clamped to 1..NUM_CHECKS (0 → 1);
  - latches timeout_i into tmo_lim_q;
  - clears stage, err, pass, fail and tmo_q;
  - sets prev_q ← check_i and run_q ← 0, so a value already present must be re-held for HOLD cycles after arm.
  - arm_i while ARMED is ignored.
- Stability filter, every edge: run_next = (check_i == prev_q) ? sat(run_q+1, HOLD+1) : 1; then prev_q ← check_i and run_q ← run_next. An event occurs on the edge where run_next == HOLD, so it fires exactly once per stable run.
- In ARMED, the following are evaluated on each edge in priority order:
  1. abort_i → FAIL, err 11.
  2. Event and check_i == exp[stage] → stage+1 and tmo_q ← 0. If stage+1 == len_q → PASS.
  3. Event and check_i == exp[j] for some stage < j < len_q → FAIL, err 10.
  4. tmo_lim_q ≠ 0 and tmo_q == tmo_lim_q−1 → FAIL, err 01.
  5. Otherwise tmo_q+1.
- Events whose value matches no active entry are ignored. Duplicate table values resolve to the expected entry (rule 2 beats rule 3).
- PASS and FAIL are sticky until arm_i or reset. abort_i outside ARMED is ignored.

## Timing
- busy_o = (state == ARMED), registered. It rises on the edge after arm_i is sampled.
- Event-to-output latency: stage_o, pass_o, fail_o and err_o change on the same edge at which the HOLD-th consecutive sample of the value is taken, and are visible in the following cycle.
- Timeout: FAIL is registered on the tmo_lim_q-th edge after the arm edge or the last stage advance, provided there was no advance on that edge. An advance on that same edge wins.
- Reset mid-run: returns to IDLE on the reset edge. The table is cleared.
- Outputs are glitch-free registers. There are no combinational paths from inputs to outputs.

## Test plan
- Pass sequence, WIDTH=16, HOLD=1: table {AB40, AB41}, len 2, timeout 0, arm. Drive AB40 then AB41 → stage_o 1 then 2; pass_o=1, err 00, busy_o=0 one cycle after the AB41 sample.
- Glitch filter, HOLD=3: AB40 held for 2 cycles, then 0000, then held for 3 cycles → exactly one advance, on the 3rd cycle of the second run. Holding AB40 for 10 further cycles causes no further change.
- Order error: table {AB40, AB41, AB42}, len 3. Drive AB40 then AB42 → fail_o=1, err 10, stage_o 1.
- Timeout: timeout 100, no checkpoint activity → fail_o on the 100th edge after arm, err 01. A matching event on exactly that edge instead gives stage 1 and no fail.
- Abort and reset: while ARMED, abort_i → err 11. Re-arm with AB40 already driven → no advance until it is held HOLD cycles after arm. wb_rst_i mid-run → all outputs 0 on the next cycle. A write while ARMED leaves the table unchanged (checked by read-back behaviour after re-arm).
